// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces the
// first key seen on the row lines, and reports its code once per physical press.
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    state_t        state, state_next;
    logic [3:0]    row_m, row_s;
    logic [3:0]    pattern, pattern_next;
    logic [1:0]    col_idx, col_idx_next;
    logic [DW-1:0] dwell, dwell_next;
    logic [BW-1:0] deb, deb_next;
    logic [3:0]    key_code_next;
    logic          key_valid_next, key_held_next;
    logic          single_zero;
    logic [1:0]    row_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    // Exactly one low row line identifies a single key; anything else is a ghost/multi-key.
    always_comb begin
        single_zero = 1'b1;
        row_idx     = 2'd0;
        case (pattern)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: single_zero = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state;
        pattern_next   = pattern;
        col_idx_next   = col_idx;
        dwell_next     = dwell;
        deb_next       = deb;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_held_next  = key_held;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (row_s != 4'hF) begin
                        pattern_next = row_s;
                        deb_next     = '0;
                        state_next   = DEB_PRESS;
                    end else begin
                        col_idx_next = col_idx + 2'd1;
                    end
                end else begin
                    dwell_next = dwell + DW'(1);
                end
            end
            DEB_PRESS: begin
                if (row_s != pattern) begin
                    deb_next     = '0;
                    dwell_next   = '0;
                    col_idx_next = col_idx + 2'd1;
                    state_next   = SCAN;
                end else if (deb == DEB_LAST) begin
                    deb_next   = '0;
                    state_next = PRESSED;
                    if (single_zero) begin
                        key_code_next  = {row_idx, col_idx};
                        key_valid_next = 1'b1;
                        key_held_next  = 1'b1;
                    end
                end else begin
                    deb_next = deb + BW'(1);
                end
            end
            PRESSED: begin
                if (row_s == 4'hF) begin
                    deb_next   = '0;
                    state_next = DEB_REL;
                end
            end
            DEB_REL: begin
                if (row_s != 4'hF) begin
                    deb_next   = '0;
                    state_next = PRESSED;
                end else if (deb == DEB_LAST) begin
                    deb_next      = '0;
                    dwell_next    = '0;
                    key_held_next = 1'b0;
                    col_idx_next  = col_idx + 2'd1;
                    state_next    = SCAN;
                end else begin
                    deb_next = deb + BW'(1);
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // col is registered from the next index so the strobe never glitches to two low bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            pattern   <= 4'hF;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            dwell     <= '0;
            deb       <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            pattern   <= pattern_next;
            col_idx   <= col_idx_next;
            col       <= ~(4'b0001 << col_idx_next);
            dwell     <= dwell_next;
            deb       <= deb_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

endmodule
